// File: rtl/rvh_noc_pkg.sv
// ---------------------------------------------------------------------------
// rvh_noc_pkg
//   Shared mesh-router types and constants used by the switch-allocation
//   front end.
//   - io_port_t          : router port encoding (N, S, E, W, L)
//   - DEFAULT_OUTPORT_NUM: default number of router output ports
//   - QoS_Value_Width    : width of the per-flit QoS field
//   - sa_inport_state_e  : per-inport SA state (IDLE / LOCKED mid-packet)
// ---------------------------------------------------------------------------
package rvh_noc_pkg;

  localparam int DEFAULT_OUTPORT_NUM = 5;
  localparam int QoS_Value_Width     = 4;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } io_port_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sa_inport_state_e;

endpackage

// File: rtl/sa_rr_one_hot_arbiter.sv
// ---------------------------------------------------------------------------
// sa_rr_one_hot_arbiter
//   Purely combinational round-robin arbiter. Scans req starting at ptr
//   (inclusive), wrapping modulo N, and grants the first set bit.
//   Ports:
//     req        in  N      request vector
//     ptr        in  IDX_W  highest-priority index for this cycle
//     gnt_onehot out N      one-hot grant (all zero when no request)
//     gnt_idx    out IDX_W  index of the granted bit (0 when no request)
// ---------------------------------------------------------------------------
module sa_rr_one_hot_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;
  int   k;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    k          = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found         = 1'b1;
        gnt_onehot[k] = 1'b1;
        gnt_idx       = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/sa_inport_vc_arbiter.sv
// ---------------------------------------------------------------------------
// sa_inport_vc_arbiter
//   First stage of switch allocation for one router input port. Picks one
//   VC with an eligible head flit, requests its look-ahead output port from
//   the global SA stage, and on grant pops that VC one cycle later.
//   A granted multi-flit packet locks the port until its tail is granted.
//
//   Optional build macro: SA_INPORT_QOS_ARB_EN
//     defined   - in IDLE only eligible VCs with the highest head QoS
//                 compete; round-robin breaks ties.
//     undefined - pure round-robin, vc_head_qos_i ignored.
//
//   Handshake: sa_req_v_o is a combinational request; sa_gnt_i answers it in
//   the same cycle. A transfer ("fire") happens only when both are 1; a
//   grant with no request is ignored. The pop follows fire by one cycle.
//
//   Ports:
//     clk, rstn                      clock, synchronous active-low reset
//     vc_head_vld_i      [VC]        head flit present per VC
//     vc_head_outport_i  [VC][OP]    one-hot look-ahead output port per VC
//     vc_head_is_tail_i  [VC]        head flit is tail / single-flit packet
//     vc_head_qos_i      [VC][QOS]   head flit QoS (optional feature only)
//     outport_rdy_i      [OP]        downstream credit per output port
//     sa_req_v_o / _outport_o / _vc_id_o   request to global SA
//     sa_gnt_i                       global grant, same cycle
//     inport_read_enable_sa_stage_o  registered pop enable
//     inport_read_vc_id_sa_stage_o   registered pop VC id (held when idle)
//     locked_o                       mid-packet lock active (FSM state)
// ---------------------------------------------------------------------------
module sa_inport_vc_arbiter
  import rvh_noc_pkg::*;
#(
  parameter int VC_NUM       = 4,
  parameter int VC_NUM_IDX_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int OUTPORT_NUM  = DEFAULT_OUTPORT_NUM,
  parameter int QOS_W        = QoS_Value_Width
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [VC_NUM-1:0]                   vc_head_vld_i,
  input  logic [VC_NUM-1:0][OUTPORT_NUM-1:0]  vc_head_outport_i,
  input  logic [VC_NUM-1:0]                   vc_head_is_tail_i,
  input  logic [VC_NUM-1:0][QOS_W-1:0]        vc_head_qos_i,
  input  logic [OUTPORT_NUM-1:0]              outport_rdy_i,
  output logic                                sa_req_v_o,
  output logic [OUTPORT_NUM-1:0]              sa_req_outport_o,
  output logic [VC_NUM_IDX_W-1:0]             sa_req_vc_id_o,
  input  logic                                sa_gnt_i,
  output logic                                inport_read_enable_sa_stage_o,
  output logic [VC_NUM_IDX_W-1:0]             inport_read_vc_id_sa_stage_o,
  output logic                                locked_o
);

  sa_inport_state_e          state_q, state_d;
  logic [VC_NUM_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [VC_NUM_IDX_W-1:0]   lock_vc_q, lock_vc_d;
  logic                      rd_en_q;
  logic [VC_NUM_IDX_W-1:0]   rd_vc_q;

  logic [VC_NUM-1:0]         eligible;
  logic [VC_NUM-1:0]         arb_req;
  logic [VC_NUM-1:0]         arb_gnt_onehot;
  logic [VC_NUM_IDX_W-1:0]   arb_gnt_idx;
  logic [VC_NUM_IDX_W-1:0]   sel;
  logic [VC_NUM_IDX_W-1:0]   sel_next;
  logic                      req_v;
  logic                      sel_tail;
  logic                      fire;

  // A head flit is eligible only if the output port it targets has credit.
  always_comb begin
    eligible = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      eligible[v] = vc_head_vld_i[v] & (|(vc_head_outport_i[v] & outport_rdy_i));
    end
  end

`ifdef SA_INPORT_QOS_ARB_EN
  // Narrow the IDLE candidates to eligible VCs carrying the highest QoS.
  logic [QOS_W-1:0] max_qos;

  always_comb begin
    max_qos = '0;
    arb_req = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (eligible[v] && (vc_head_qos_i[v] > max_qos)) begin
        max_qos = vc_head_qos_i[v];
      end
    end
    for (int v = 0; v < VC_NUM; v++) begin
      arb_req[v] = eligible[v] && (vc_head_qos_i[v] == max_qos);
    end
  end
`else
  logic unused_qos;

  assign arb_req    = eligible;
  assign unused_qos = ^vc_head_qos_i;
`endif

  sa_rr_one_hot_arbiter #(
    .N     (VC_NUM),
    .IDX_W (VC_NUM_IDX_W)
  ) u_rr_arb (
    .req        (arb_req),
    .ptr        (rr_ptr_q),
    .gnt_onehot (arb_gnt_onehot),
    .gnt_idx    (arb_gnt_idx)
  );

  // While locked, the arbiter result is ignored: only the locked VC may ask.
  always_comb begin
    if (state_q == LOCKED) begin
      sel   = lock_vc_q;
      req_v = eligible[lock_vc_q];
    end else begin
      sel   = arb_gnt_idx;
      req_v = |arb_gnt_onehot;
    end
  end

  assign sel_tail = vc_head_is_tail_i[sel];
  assign fire     = req_v & sa_gnt_i;
  assign sel_next = (sel == VC_NUM_IDX_W'(VC_NUM - 1)) ? '0
                                                       : sel + VC_NUM_IDX_W'(1);

  assign sa_req_v_o       = req_v;
  assign sa_req_outport_o = req_v ? vc_head_outport_i[sel] : '0;
  assign sa_req_vc_id_o   = req_v ? sel : '0;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_vc_d = lock_vc_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (sel_tail) begin
            rr_ptr_d = sel_next;
          end else begin
            state_d   = LOCKED;
            lock_vc_d = sel;
          end
        end
      end
      LOCKED: begin
        // No timeout: a missing body flit or credit simply keeps the lock.
        if (fire && sel_tail) begin
          state_d  = IDLE;
          rr_ptr_d = sel_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      lock_vc_q <= '0;
      rd_en_q   <= 1'b0;
      rd_vc_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_vc_q <= lock_vc_d;
      rd_en_q   <= fire;
      if (fire) begin
        rd_vc_q <= sel;
      end
    end
  end

  assign inport_read_enable_sa_stage_o = rd_en_q;
  assign inport_read_vc_id_sa_stage_o  = rd_vc_q;
  assign locked_o                      = (state_q == LOCKED);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rstn) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (vc_head_vld_i[v]) begin
          assert ($onehot(vc_head_outport_i[v]));
        end
      end
      if (sa_req_v_o) begin
        assert ($onehot(sa_req_outport_o));
      end
    end
  end
`endif

endmodule

// File: tb/tb_sa_inport_vc_arbiter.sv
module tb_sa_inport_vc_arbiter;

  localparam int VC  = 4;
  localparam int IW  = 2;
  localparam int OP  = 5;
  localparam int QW  = 4;
  localparam logic [OP-1:0] OP_N = 5'b00001;
  localparam logic [OP-1:0] OP_E = 5'b00100;

  logic                   clk;
  logic                   rstn;
  logic [VC-1:0]          vc_head_vld_i;
  logic [VC-1:0][OP-1:0]  vc_head_outport_i;
  logic [VC-1:0]          vc_head_is_tail_i;
  logic [VC-1:0][QW-1:0]  vc_head_qos_i;
  logic [OP-1:0]          outport_rdy_i;
  logic                   sa_req_v_o;
  logic [OP-1:0]          sa_req_outport_o;
  logic [IW-1:0]          sa_req_vc_id_o;
  logic                   sa_gnt_i;
  logic                   inport_read_enable_sa_stage_o;
  logic [IW-1:0]          inport_read_vc_id_sa_stage_o;
  logic                   locked_o;

  sa_inport_vc_arbiter dut (
    .clk                           (clk),
    .rstn                          (rstn),
    .vc_head_vld_i                 (vc_head_vld_i),
    .vc_head_outport_i             (vc_head_outport_i),
    .vc_head_is_tail_i             (vc_head_is_tail_i),
    .vc_head_qos_i                 (vc_head_qos_i),
    .outport_rdy_i                 (outport_rdy_i),
    .sa_req_v_o                    (sa_req_v_o),
    .sa_req_outport_o              (sa_req_outport_o),
    .sa_req_vc_id_o                (sa_req_vc_id_o),
    .sa_gnt_i                      (sa_gnt_i),
    .inport_read_enable_sa_stage_o (inport_read_enable_sa_stage_o),
    .inport_read_vc_id_sa_stage_o  (inport_read_vc_id_sa_stage_o),
    .locked_o                      (locked_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [IW:0]   exp_q[$];     // {read_enable, read_vc_id} expected one cycle later
  logic [IW-1:0] exp_rd_vc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called just after a negedge with inputs already applied. Checks the
  // combinational request, the lock flag, and the pop registered from the
  // previous cycle; then queues this cycle's expected pop.
  task automatic tick(input string tag, input logic exp_v, input logic [IW-1:0] exp_vc,
                      input logic [OP-1:0] exp_op, input logic exp_lock);
    logic [IW:0] e;
    logic        exp_en;
    #1;
    check({tag, "_req_v"},   32'(sa_req_v_o),       32'(exp_v));
    check({tag, "_req_vc"},  32'(sa_req_vc_id_o),   exp_v ? 32'(exp_vc) : 32'd0);
    check({tag, "_req_op"},  32'(sa_req_outport_o), exp_v ? 32'(exp_op) : 32'd0);
    check({tag, "_locked"},  32'(locked_o),         32'(exp_lock));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_rd_en"}, 32'(inport_read_enable_sa_stage_o), 32'(e[IW]));
      check({tag, "_rd_vc"}, 32'(inport_read_vc_id_sa_stage_o),  32'(e[IW-1:0]));
    end
    exp_en = exp_v & sa_gnt_i;
    if (exp_en) exp_rd_vc = exp_vc;
    exp_q.push_back({exp_en, exp_rd_vc});
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    vc_head_vld_i     = '0;
    vc_head_outport_i = '0;
    vc_head_is_tail_i = '0;
    vc_head_qos_i     = '0;
    outport_rdy_i     = '0;
    sa_gnt_i          = 1'b0;
  endtask

  task automatic set_all(input logic [VC-1:0] vld, input logic [VC-1:0] tail, input logic [OP-1:0] op);
    vc_head_vld_i     = vld;
    vc_head_is_tail_i = tail;
    for (int v = 0; v < VC; v++) vc_head_outport_i[v] = op;
  endtask

  // Entered at a negedge: hold reset across one posedge, check the reset
  // state, release at the following negedge.
  task automatic do_reset(input string tag);
    clear_inputs();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_locked"}, 32'(locked_o), 32'd0);
    check({tag, "_rd_en"},  32'(inport_read_enable_sa_stage_o), 32'd0);
    check({tag, "_rd_vc"},  32'(inport_read_vc_id_sa_stage_o),  32'd0);
    check({tag, "_req_v"},  32'(sa_req_v_o), 32'd0);
    exp_q.delete();
    exp_rd_vc = '0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [VC-1:0] elig;
    logic          m_v;
    logic [IW-1:0] m_sel;
    int            ptr_m;
    int            idx;

    rstn = 1'b0;
    clear_inputs();
    exp_rd_vc = '0;
    @(negedge clk);
    do_reset("rst0");

    // Single-flit round robin
    set_all(4'hF, 4'hF, OP_E);
    outport_rdy_i = '1;
    sa_gnt_i      = 1'b1;
    tick("rr0", 1, 0, OP_E, 0);
    tick("rr1", 1, 1, OP_E, 0);
    tick("rr2", 1, 2, OP_E, 0);
    tick("rr3", 1, 3, OP_E, 0);
    tick("rr4", 1, 0, OP_E, 0);           // wrap 3 -> 0; pointer now 1

    // Wormhole lock: VC1 three-flit packet with VC2 waiting
    set_all(4'b0110, 4'b0100, OP_E);
    tick("wh_head", 1, 1, OP_E, 0);
    tick("wh_body", 1, 1, OP_E, 1);
    vc_head_is_tail_i = 4'b0110;
    tick("wh_tail", 1, 1, OP_E, 1);
    vc_head_vld_i = 4'b0100;
    tick("wh_next", 1, 2, OP_E, 0);       // pointer now 3

    // Lock bubble: VC1 locked, body absent while VC0 is ready
    set_all(4'b0010, 4'b0000, OP_E);
    tick("bub_head", 1, 1, OP_E, 0);
    set_all(4'b0001, 4'b0001, OP_E);
    for (int i = 0; i < 3; i++) tick("bub_gap", 0, 0, OP_E, 1);
    set_all(4'b0011, 4'b0011, OP_E);
    tick("bub_tail", 1, 1, OP_E, 1);
    vc_head_vld_i = 4'b0001;
    tick("bub_vc0", 1, 0, OP_E, 0);       // pointer now 1

    // Credit stall on outport N for VC3
    set_all(4'b1000, 4'hF, OP_E);
    vc_head_outport_i[3] = OP_N;
    outport_rdy_i = 5'b11110;
    tick("cr_stall0", 0, 0, OP_N, 0);
    tick("cr_stall1", 0, 0, OP_N, 0);
    outport_rdy_i = '1;
    tick("cr_go", 1, 3, OP_N, 0);         // pointer now 0

    // Grant denied keeps pointer and re-requests the same VC
    set_all(4'hF, 4'hF, OP_E);
    sa_gnt_i = 1'b0;
    tick("gd0", 1, 0, OP_E, 0);
    tick("gd1", 1, 0, OP_E, 0);
    sa_gnt_i = 1'b1;
    tick("gd2", 1, 0, OP_E, 0);
    tick("gd3", 1, 1, OP_E, 0);           // pointer now 2

    // Reset while locked on VC2
    set_all(4'hF, 4'h0, OP_E);
    tick("rl_head", 1, 2, OP_E, 0);
    tick("rl_body", 1, 2, OP_E, 1);
    do_reset("rst_mid");

    // After reset: VC0 qos 1, VC3 qos 7 (pointer back at 0)
    set_all(4'b1001, 4'hF, OP_E);
    vc_head_qos_i[0] = 4'd1;
    vc_head_qos_i[3] = 4'd7;
    outport_rdy_i    = '1;
    sa_gnt_i         = 1'b1;
`ifdef SA_INPORT_QOS_ARB_EN
    tick("qos", 1, 3, OP_E, 0);
`else
    tick("qos", 1, 0, OP_E, 0);
`endif

    // Random single-flit traffic against a reference round-robin model
    @(negedge clk);
    do_reset("rst_rand");
    ptr_m = 0;
    for (int c = 0; c < 60; c++) begin
      vc_head_vld_i     = 4'($urandom_range(0, 15));
      vc_head_is_tail_i = '1;
      vc_head_qos_i     = '0;
      for (int v = 0; v < VC; v++) vc_head_outport_i[v] = OP'(1 << $urandom_range(0, OP - 1));
      outport_rdy_i = 5'($urandom_range(0, 31));
      sa_gnt_i      = 1'($urandom_range(0, 1));
      for (int v = 0; v < VC; v++) elig[v] = vc_head_vld_i[v] && ((vc_head_outport_i[v] & outport_rdy_i) != 0);
      m_v   = 1'b0;
      m_sel = '0;
      for (int i = 0; i < VC; i++) begin
        idx = (ptr_m + i) % VC;
        if (!m_v && elig[idx]) begin
          m_v   = 1'b1;
          m_sel = IW'(idx);
        end
      end
      tick("rand", m_v, m_sel, vc_head_outport_i[m_sel], 0);
      if (m_v && sa_gnt_i) ptr_m = (int'(m_sel) + 1) % VC;
    end

    clear_inputs();
    tick("drain", 0, 0, '0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
